uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: byte FIFO with overrun tracking, CPU register
// interface (RXD/STAT/CTRL) and a registered receive interrupt.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [3:0] AddrRxd  = 4'h0;
  localparam logic [3:0] AddrStat = 4'h4;
  localparam logic [3:0] AddrCtrl = 4'h8;
  localparam logic [4:0] CountFull = 5'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          rx_en_q, rx_en_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;

  logic not_empty, full;
  logic pop, push, ovr_set, stat_rd, ctrl_wr, flush;

  assign not_empty = (count_q != 5'd0);
  assign full      = (count_q == CountFull);

  assign ctrl_wr = wr && (addr == AddrCtrl);
  assign flush   = ctrl_wr && wdata[2];
  assign stat_rd = rd && (addr == AddrStat);
  assign pop     = rd && (addr == AddrRxd) && not_empty;
  // A flush in the same cycle drops the incoming byte without flagging overrun.
  assign push    = rx_valid && rx_en_q && !flush && (!full || pop);
  assign ovr_set = rx_valid && rx_en_q && !flush && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    rx_en_d  = rx_en_q;
    irq_en_d = irq_en_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
      ovr_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      // Set wins over the read-to-clear of STAT.
      if (ovr_set)      ovr_d = 1'b1;
      else if (stat_rd) ovr_d = 1'b0;
    end

    if (ctrl_wr) begin
      rx_en_d  = wdata[0];
      irq_en_d = wdata[1];
    end

    irq_d = irq_en_d && ((count_d != 5'd0) || ovr_d);
  end

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      unique case (addr)
        AddrRxd:  rdata = not_empty ? {24'h0, mem_q[rd_ptr_q]} : 32'h0;
        AddrStat: rdata = {23'h0, count_q, 1'b0, ovr_q, full, not_empty};
        AddrCtrl: rdata = {30'h0, irq_en_q, rx_en_q};
        default:  rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      ovr_q    <= 1'b0;
      rx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      rx_en_q  <= rx_en_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is readable.
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: reads push expected rdata into a queue,
// a negedge monitor pops and compares whenever rd is asserted.
module tb_uart_rx_ctrl;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rd;
  logic        wr;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  string       nm_q  [$];

  uart_rx_ctrl #(.DEPTH(4)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every read cycle is compared against the oldest expectation.
  always @(negedge sysclk) begin
    if (rd === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
      end else begin
        check(nm_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  // One bus cycle; inputs applied at posedge+1, released after the next edge.
  task automatic bus(input logic rxv, input logic [7:0] b, input logic r, input logic w,
                     input logic [3:0] a, input logic [31:0] wd, input logic [31:0] exp,
                     input string nm);
    rx_valid = rxv;
    rx_byte  = b;
    rd       = r;
    wr       = w;
    addr     = a;
    wdata    = wd;
    if (r) begin
      exp_q.push_back(exp);
      nm_q.push_back(nm);
    end
    @(posedge sysclk);
    #1;
    rx_valid = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus(1'b1, b, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "");
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] exp, input string nm);
    bus(1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0, exp, nm);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    bus(1'b0, 8'h00, 1'b0, 1'b1, a, d, 32'h0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rd       = 1'b0;
    wr       = 1'b0;
    addr     = 4'h0;
    wdata    = 32'h0;
    repeat (3) @(posedge sysclk);
    #1;
    reset = 1'b1;

    // Reset state
    check("irq_after_reset", {31'h0, irq}, 32'h0);
    rd_reg(4'h8, 32'h1, "ctrl_reset");
    rd_reg(4'h4, 32'h0, "stat_reset");
    rd_reg(4'h0, 32'h0, "rxd_reset_empty");

    // Basic two-byte transfer
    push(8'h41);
    push(8'h42);
    rd_reg(4'h4, 32'h021, "stat_two");
    rd_reg(4'h0, 32'h41, "rxd_0x41");
    rd_reg(4'h0, 32'h42, "rxd_0x42");
    rd_reg(4'h4, 32'h000, "stat_drained");
    check("rdata_rd_low", rdata, 32'h0);

    // Overrun on a full FIFO
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    rd_reg(4'h4, 32'h047, "stat_ovr");
    rd_reg(4'h4, 32'h043, "stat_ovr_cleared");
    for (int i = 0; i < 4; i++) rd_reg(4'h0, 32'h10 + 32'(i), "rxd_ovr_seq");
    rd_reg(4'h4, 32'h000, "stat_after_ovr_drain");

    // Push and pop together on a full FIFO
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    bus(1'b1, 8'h55, 1'b1, 1'b0, 4'h0, 32'h0, 32'h20, "rxd_full_pushpop");
    rd_reg(4'h4, 32'h043, "stat_full_pushpop");
    rd_reg(4'h0, 32'h21, "rxd_fp_1");
    rd_reg(4'h0, 32'h22, "rxd_fp_2");
    rd_reg(4'h0, 32'h23, "rxd_fp_3");
    rd_reg(4'h0, 32'h55, "rxd_fp_last");

    // Read of empty FIFO with simultaneous push
    bus(1'b1, 8'h66, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, "rxd_empty_with_push");
    rd_reg(4'h4, 32'h011, "stat_empty_push");
    rd_reg(4'h0, 32'h66, "rxd_0x66");

    // rx_en=0 ignores bytes
    wr_reg(4'h8, 32'h2);
    push(8'hEE);
    check("irq_rx_disabled", {31'h0, irq}, 32'h0);
    rd_reg(4'h4, 32'h000, "stat_rx_disabled");
    rd_reg(4'h8, 32'h2, "ctrl_0x2");

    // Interrupt assertion and deassertion
    wr_reg(4'h8, 32'h3);
    push(8'hA5);
    check("irq_after_push", {31'h0, irq}, 32'h1);
    rd_reg(4'h0, 32'hA5, "rxd_0xa5");
    check("irq_after_pop", {31'h0, irq}, 32'h0);
    push(8'h77);
    check("irq_push2", {31'h0, irq}, 32'h1);
    wr_reg(4'h8, 32'h1);
    check("irq_en_cleared", {31'h0, irq}, 32'h0);
    rd_reg(4'h0, 32'h77, "rxd_0x77");

    // Flush beats a coincident byte
    wr_reg(4'h8, 32'h3);
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    check("irq_before_flush", {31'h0, irq}, 32'h1);
    rd_reg(4'h0, 32'h30, "rxd_0x30");
    bus(1'b1, 8'h99, 1'b0, 1'b1, 4'h8, 32'h7, 32'h0, "");
    check("irq_after_flush", {31'h0, irq}, 32'h0);
    rd_reg(4'h4, 32'h000, "stat_after_flush");
    rd_reg(4'h0, 32'h0, "rxd_after_flush");
    rd_reg(4'h8, 32'h3, "ctrl_flush_bit_zero");

    // Read and write in one cycle: rdata shows pre-edge state
    bus(1'b0, 8'h00, 1'b1, 1'b1, 4'h8, 32'h1, 32'h3, "ctrl_rdwr_old");
    rd_reg(4'h8, 32'h1, "ctrl_rdwr_new");

    // Writes outside CTRL have no effect
    push(8'h12);
    wr_reg(4'hC, 32'h6);
    wr_reg(4'h4, 32'h4);
    wr_reg(4'h0, 32'h4);
    rd_reg(4'h4, 32'h011, "stat_after_bad_writes");
    rd_reg(4'hC, 32'h0, "unmapped_read");
    rd_reg(4'h8, 32'h1, "ctrl_after_bad_writes");
    rd_reg(4'h0, 32'h12, "rxd_0x12");

    // Asynchronous reset between edges
    wr_reg(4'h8, 32'h3);
    push(8'hB1);
    push(8'hB2);
    check("irq_before_reset", {31'h0, irq}, 32'h1);
    #1;
    reset = 1'b0;
    rd    = 1'b1;
    addr  = 4'h4;
    exp_q.push_back(32'h0);
    nm_q.push_back("stat_async_reset");
    #1;
    check("irq_async_reset", {31'h0, irq}, 32'h0);
    @(negedge sysclk);
    #1;
    addr = 4'h8;
    exp_q.push_back(32'h1);
    nm_q.push_back("ctrl_in_reset");
    @(negedge sysclk);
    #1;
    rd = 1'b0;
    @(posedge sysclk);
    #1;
    reset = 1'b1;
    push(8'hC3);
    check("irq_en_reset_cleared", {31'h0, irq}, 32'h0);
    rd_reg(4'h4, 32'h011, "stat_post_reset");
    rd_reg(4'h0, 32'hC3, "rxd_post_reset");
    rd_reg(4'h8, 32'h1, "ctrl_post_reset");

    // Drain the scoreboard within a bounded time
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge sysclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
